// File: rtl/pipeline_pkg.sv
// Shared constants and types for the pipelined MIPS core front end.
package pipeline_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned FETCH_ENTRY_W    = 64;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Fetch buffer: power-of-two deep FIFO with synchronous flush and head-of-queue output.
module if_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset; the consumer ignores head while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/pipeline_if.sv
// Instruction-fetch stage: owns the fetch PC, issues memory reads and buffers words for decode.
// Define IF_BYPASS_EN to forward a response that finds the buffer empty straight to decode.
module pipeline_if
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_pcplus4,
  output logic [31:0] id_instr
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [31:0]      fetch_pc_q, fetch_pc_d, grant_pc_q;
  logic             pending_q, pending_d, discard_q, discard_d;
  logic             grant, resp, push, pop, bypass, fifo_empty;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  fetch_entry_t     head, out_entry;

  assign resp  = imem_rvalid && pending_q;
  assign grant = imem_req && imem_gnt;

`ifdef IF_BYPASS_EN
  assign bypass    = fifo_empty && resp && !discard_q && !redirect;
  assign out_entry = fifo_empty ? fetch_entry_t'{pc: grant_pc_q, instr: imem_rdata} : head;
`else
  assign bypass    = 1'b0;
  assign out_entry = head;
`endif

  assign id_valid = !redirect && (!fifo_empty || bypass);
  assign pop      = id_valid && id_ready && !fifo_empty;
  assign push     = resp && !discard_q && !redirect && !(bypass && id_ready);

  // Counting the same-cycle pop lets a two-entry buffer sustain one fetch per cycle.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, pending_q} - {{CNT_W{1'b0}}, pop};
  assign imem_req  = !redirect && (!pending_q || imem_rvalid) &&
                     (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc_q;

  always_comb begin
    id_pc      = '0;
    id_pcplus4 = '0;
    id_instr   = INSTR_NOP;
    if (id_valid) begin
      id_pc      = out_entry.pc;
      id_pcplus4 = out_entry.pc + 32'd4;
      id_instr   = out_entry.instr;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pending_d  = pending_q;
    discard_d  = discard_q;
    if (resp) begin
      pending_d = 1'b0;
      discard_d = 1'b0;
    end
    if (grant) begin
      pending_d  = 1'b1;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
      // The in-flight word belongs to the old path; drop it when it lands.
      if (pending_q && !imem_rvalid) discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      grant_pc_q <= '0;
      pending_q  <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= pending_d;
      discard_q  <= discard_d;
      if (grant) grant_pc_q <= fetch_pc_q;
    end
  end

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({grant_pc_q, imem_rdata}),
    .head  (head),
    .count (count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_pipeline_if.sv
// Scoreboard bench for pipeline_if: a memory model answers grants, a monitor checks accepted words.
module tb_pipeline_if;

`ifdef IF_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_pc, id_pcplus4, id_instr;

  int          errors = 0;
  int          checks = 0;
  int unsigned mem_lat = 1;
  int unsigned cyc = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcplus4;
  } exp_t;

  typedef struct packed {
    int unsigned due;
    logic [31:0] addr;
  } resp_t;

  exp_t  exp_q[$];
  resp_t resp_q[$];

  always #5 clk = ~clk;

  pipeline_if #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_pcplus4  (id_pcplus4),
    .id_instr    (id_instr)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h2400_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Instruction memory: grant seen in cycle k returns data in cycle k + mem_lat.
  initial begin : memory
    resp_t r;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
        r           = resp_q.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(r.addr);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_DEAD;
      end
      @(negedge clk);
      if (reset && imem_req && imem_gnt) resp_q.push_back('{due: cyc + mem_lat, addr: imem_addr});
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && id_valid && id_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("id_pc", id_pc, e.pc);
        check("id_pcplus4", id_pcplus4, e.pcplus4);
        check("id_instr", id_instr, mem_word(e.pc));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run still active at 100000, expected earlier finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic expect_pc(input logic [31:0] pc, input logic [31:0] p4);
    exp_q.push_back('{pc: pc, pcplus4: p4});
  endtask

  // Holds reset for a few cycles, checks idle outputs, and releases it at the start of cycle 0.
  task automatic start(input int unsigned lat, input logic ready);
    step();
    reset    = 1'b0;
    redirect = 1'b0;
    imem_gnt = 1'b1;
    id_ready = ready;
    mem_lat  = lat;
    exp_q.delete();
    repeat (4) step();
    settle();
    check("reset id_valid", 32'(id_valid), 32'h0);
    check("reset id_pc", id_pc, 32'h0);
    check("reset id_pcplus4", id_pcplus4, 32'h0);
    check("reset id_instr", id_instr, 32'h0);
    check("reset imem_req", 32'(imem_req), 32'h1);
    check("reset imem_addr", imem_addr, 32'h0);
    step();
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d words outstanding, expected 0", name, exp_q.size());
    end
  endtask

  initial begin : stimulus
    // Streaming at one word per cycle.
    start(1, 1'b1);
    expect_pc(32'h0, 32'h4);
    expect_pc(32'h4, 32'h8);
    expect_pc(32'h8, 32'hC);
    expect_pc(32'hC, 32'h10);
    settle();
    check("t1 c0 imem_req", 32'(imem_req), 32'h1);
    check("t1 c0 imem_addr", imem_addr, 32'h0);
    step(); settle();
    check("t1 c1 imem_addr", imem_addr, 32'h4);
    check("t1 c1 id_valid", 32'(id_valid), 32'(BYP));
    step(); settle();
    check("t1 c2 imem_addr", imem_addr, 32'h8);
    check("t1 c2 id_valid", 32'(id_valid), 32'h1);
    step(); settle();
    check("t1 c3 imem_addr", imem_addr, 32'hC);
    check("t1 c3 id_valid", 32'(id_valid), 32'h1);
    drain("t1");

    // Decode stall fills the buffer, then releases in order.
    start(1, 1'b0);
    expect_pc(32'h0, 32'h4);
    expect_pc(32'h4, 32'h8);
    expect_pc(32'h8, 32'hC);
    expect_pc(32'hC, 32'h10);
    settle();
    step(); settle();
    step(); settle();
    check("t2 c2 imem_req", 32'(imem_req), 32'h0);
    step(); settle();
    step(); settle();
    check("t2 c4 imem_req", 32'(imem_req), 32'h0);
    check("t2 c4 id_valid", 32'(id_valid), 32'h1);
    check("t2 c4 id_pc", id_pc, 32'h0);
    check("t2 c4 id_instr", id_instr, mem_word(32'h0));
    step();
    id_ready = 1'b1;
    settle();
    check("t2 c5 imem_req", 32'(imem_req), 32'h1);
    check("t2 c5 imem_addr", imem_addr, 32'h8);
    drain("t2");

    // Redirect while a 3-cycle fetch is in flight.
    start(3, 1'b1);
    expect_pc(32'h100, 32'h104);
    expect_pc(32'h104, 32'h108);
    expect_pc(32'h108, 32'h10C);
    settle();
    check("t3 c0 imem_addr", imem_addr, 32'h0);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    settle();
    check("t3 c1 imem_req", 32'(imem_req), 32'h0);
    check("t3 c1 id_valid", 32'(id_valid), 32'h0);
    step();
    redirect = 1'b0;
    settle();
    check("t3 c2 imem_req", 32'(imem_req), 32'h0);
    step(); settle();
    check("t3 c3 imem_req", 32'(imem_req), 32'h1);
    check("t3 c3 imem_addr", imem_addr, 32'h100);
    check("t3 c3 id_valid", 32'(id_valid), 32'h0);
    step(); settle();
    check("t3 c4 id_valid", 32'(id_valid), 32'h0);
    drain("t3");

    // Redirect coinciding with a response and a pop.
    start(1, 1'b1);
    settle();
    step(); settle();
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    settle();
    check("t4 c2 id_valid", 32'(id_valid), 32'h0);
    check("t4 c2 imem_req", 32'(imem_req), 32'h0);
    step();
    redirect = 1'b0;
    expect_pc(32'h200, 32'h204);
    expect_pc(32'h204, 32'h208);
    expect_pc(32'h208, 32'h20C);
    settle();
    check("t4 c3 imem_req", 32'(imem_req), 32'h1);
    check("t4 c3 imem_addr", imem_addr, 32'h200);
    check("t4 c3 id_valid", 32'(id_valid), 32'h0);
    step(); settle();
    check("t4 c4 id_valid", 32'(id_valid), 32'(BYP));
    step(); settle();
    check("t4 c5 id_valid", 32'(id_valid), 32'h1);
    drain("t4");

    // Fetch address wraps at the top of the address space.
    start(1, 1'b1);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    settle();
    check("t5 c0 imem_req", 32'(imem_req), 32'h0);
    step();
    redirect = 1'b0;
    expect_pc(32'hFFFF_FFFC, 32'h0);
    expect_pc(32'h0, 32'h4);
    expect_pc(32'h4, 32'h8);
    settle();
    check("t5 c1 imem_addr", imem_addr, 32'hFFFF_FFFC);
    step(); settle();
    check("t5 c2 imem_addr", imem_addr, 32'h0);
    drain("t5");

    // Reset mid-fetch; the late response must be ignored.
    start(3, 1'b1);
    settle();
    step();
    reset = 1'b0;
    settle();
    check("t6 c1 id_valid", 32'(id_valid), 32'h0);
    step();
    reset    = 1'b1;
    imem_gnt = 1'b0;
    settle();
    check("t6 c2 imem_req", 32'(imem_req), 32'h1);
    check("t6 c2 imem_addr", imem_addr, 32'h0);
    step(); settle();
    check("t6 c3 id_valid", 32'(id_valid), 32'h0);
    step();
    imem_gnt = 1'b1;
    expect_pc(32'h0, 32'h4);
    expect_pc(32'h4, 32'h8);
    settle();
    check("t6 c4 id_valid", 32'(id_valid), 32'h0);
    step(); settle();
    step(); settle();
    step(); settle();
    check("t6 c7 id_valid", 32'(id_valid), 32'(BYP));
    step(); settle();
    check("t6 c8 id_valid", 32'(id_valid), 32'(!BYP));
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
